cfg_chain_loader: RTL and testbench
===================================

// Module: cfg_chain_loader
// PURPOSE
//  Configuration controller for the tinyFPGA serial programming chain.
//  - Accepts a bitstream as a byte stream and shifts it, one bit per clock, into the chain (prog_en/prog_in).
//  - Then recirculates the chain once (prog_out -> prog_in), CRC-checking the readback against the loaded stream.
//  - Holds the fabric in reset until configuration is verified. Sits between the host/IO shim and the fabric top.
// PARAMETERS
//  CHAIN_LEN  176  total config bits in the chain (BELS x per-BEL bits + cluster routing bits); >= 1
//  CNT_W      8    width of the bit counter; must satisfy 2**CNT_W > CHAIN_LEN
//  CRC_INIT   16'hFFFF  CRC-16-CCITT seed (poly 16'h1021, MSB-first register, bit-serial update)
// PORTS
//  clk          in   1      system clock
//  rst          in   1      synchronous reset, active-high
//  start        in   1      1-cycle pulse: begin a configuration (ignored unless IDLE, DONE or ERROR)
//  abort        in   1      level: abandon current load/verify
//  s_data       in   8      bitstream byte, LSB shifted first
//  s_valid      in   1      s_data valid
//  s_ready      out  1      byte consumed this cycle when s_valid && s_ready
//  prog_en      out  1      chain shift enable; chain shifts on clk when 1
//  prog_in      out  1      serial bit into chain
//  prog_out     in   1      serial bit out of chain tail
//  fabric_rst   out  1      reset to user fabric; 1 until verify passes
//  busy         out  1      LOAD or VERIFY in progress
//  done         out  1      configuration loaded and verified (sticky until next start)
//  crc_err      out  1      readback CRC mismatch (sticky until next start)
// BEHAVIOUR
//  Reset: state=IDLE; s_ready=0, prog_en=0, prog_in=0, fabric_rst=1, busy=0, done=0, crc_err=0; counters and CRCs cleared.
//  States: IDLE -start-> LOAD -bit_cnt==CHAIN_LEN-> VERIFY -bit_cnt==CHAIN_LEN-> DONE (crc match) | ERROR (mismatch).
//          DONE/ERROR -start-> LOAD. abort in LOAD/VERIFY -> IDLE next cycle; abort in other states has no effect.
//  Entering LOAD: bit_cnt=0, crc_ld=CRC_INIT, done=0, crc_err=0, fabric_rst=1.
//  LOAD:
//   - Byte buffer holds the current byte plus a 3-bit index.
//   - s_ready=1 only when the buffer is empty, i.e. on the first cycle of LOAD or when the buffer was drained the previous cycle.
//   - Each cycle the buffer holds a bit: prog_en=1, prog_in=buf[idx], crc_ld updated with that bit, bit_cnt++.
//   - Buffer empty and s_valid=0: prog_en=0 and the chain holds. The stall may last any number of cycles with no bit lost.
//   - A byte accepted at a stall/drain boundary is loaded and its bit 0 shifts on the following cycle. Latency is 1 cycle from accept to first bit.
//   - After CHAIN_LEN bits, remaining bits of the final byte are discarded and the buffer is cleared. s_ready=0 from then until the next LOAD.
//  VERIFY:
//   - Entered with bit_cnt=0, crc_rb=CRC_INIT.
//   - Every cycle: prog_en=1, prog_in=prog_out (recirculate, chain contents preserved), crc_rb updated with prog_out, bit_cnt++.
//   - Exactly CHAIN_LEN cycles, no stalls.
//  DONE: prog_en=0, fabric_rst=0, done=1. ERROR: prog_en=0, fabric_rst=1, crc_err=1.
//  busy=1 exactly in LOAD and VERIFY. fabric_rst=1 in every state except DONE.
//  prog_en, prog_in and s_ready are combinational from state/buffer. All other outputs are registered.
//  start and abort in the same cycle: abort wins.
//  rst mid-operation: immediate return to reset values; a partially shifted chain is not cleared (it is reloaded on the next start).
//  CHAIN_LEN not a multiple of 8: byte count = ceil(CHAIN_LEN/8), upper bits of the last byte ignored.
// STRUCTURE
//  cfg_pkg: CRC_POLY, CRC_INIT, state enum {ST_IDLE, ST_LOAD, ST_VERIFY, ST_DONE, ST_ERROR}, crc16_step() function.
//  Sub-module crc16_serial (clear, en, bit_in -> crc[15:0]), instantiated twice (load stream and readback).
//  Top: FSM + byte buffer + bit counter + comparator.
// TESTING (bench models the chain as a CHAIN_LEN-bit shift register driven by prog_en/prog_in)
//  1 Reset, then idle 5 cycles -> fabric_rst=1, prog_en=0, s_ready=0, done=0, crc_err=0.
//  2 start + 22 bytes 0xA5 back-to-back -> prog_en high for 176+176 cycles; chain model holds 0xA5 pattern LSB-first; done=1, fabric_rst=0 the cycle after the last verify bit.
//  3 Same as 2 with s_valid dropped for 7 cycles after byte 3 -> prog_en=0 exactly those 7 cycles; chain contents identical to 2; done=1.
//  4 Bench flips one chain bit (index 50) during VERIFY -> crc_err=1, done=0, fabric_rst stays 1; a new start with a clean load clears crc_err and ends in done=1.
//  5 abort after 40 LOAD bits -> IDLE next cycle, busy=0, s_ready=0, no further prog_en; rst pulse after 100 VERIFY bits -> all outputs at reset values next cycle.
//  6 CHAIN_LEN=13 build: 2 bytes 0xFF,0x0F accepted -> exactly 13 bits shifted, top 3 bits of byte 2 dropped, done=1.

Source files
------------

// File: rtl/cfg_chain_loader_pkg.sv
// Shared types and CRC-16-CCITT helper for the configuration chain loader.
package cfg_chain_loader_pkg;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_VERIFY,
        ST_DONE,
        ST_ERROR
    } state_e;

    // One MSB-first bit-serial step of CRC-16-CCITT.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
        logic fb;
        fb = crc[15] ^ bit_in;
        return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/cfg_chain_loader_crc16.sv
// Bit-serial CRC-16-CCITT accumulator; clear reloads the seed and wins over en.
module crc16_serial #(
    parameter logic [15:0] INIT = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        en,
    input  logic        bit_in,
    output logic [15:0] crc
);
    import cfg_chain_loader_pkg::*;

    logic [15:0] crc_q;

    // NOTE: state registers are written with non-blocking assignments only, so every
    // always_ff samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            crc_q <= INIT;
        end else if (clear) begin
            crc_q <= INIT;
        end else if (en) begin
            crc_q <= crc16_step(crc_q, bit_in);
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/cfg_chain_loader.sv
// Shifts a byte-streamed bitstream into the serial config chain, recirculates it once
// to CRC-check the readback, and holds the fabric in reset until the check passes.
module cfg_chain_loader #(
    parameter int unsigned CHAIN_LEN = 176,
    parameter int unsigned CNT_W     = 8,
    parameter logic [15:0] CRC_INIT  = 16'hFFFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    output logic       prog_en,
    output logic       prog_in,
    input  logic       prog_out,
    output logic       fabric_rst,
    output logic       busy,
    output logic       done,
    output logic       crc_err
);
    import cfg_chain_loader_pkg::*;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [7:0]       buf_q, buf_d;
    logic [2:0]       idx_q, idx_d;
    logic             buf_vld_q, buf_vld_d;
    logic             busy_q, done_q, crc_err_q, fabric_rst_q;

    logic             ld_shift, rb_shift, last_bit;
    logic             ld_clear, rb_clear;
    logic [15:0]      crc_ld, crc_rb;

    assign ld_shift = (state_q == ST_LOAD) && buf_vld_q;
    assign rb_shift = (state_q == ST_VERIFY);
    assign last_bit = (bit_cnt_q == LAST_BIT);

    assign s_ready    = (state_q == ST_LOAD) && !buf_vld_q;
    assign prog_en    = ld_shift || rb_shift;
    assign prog_in    = ld_shift ? buf_q[idx_q] : (rb_shift ? prog_out : 1'b0);
    assign busy       = busy_q;
    assign done       = done_q;
    assign crc_err    = crc_err_q;
    assign fabric_rst = fabric_rst_q;

    // NOTE: every signal written here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        buf_d     = buf_q;
        idx_d     = idx_q;
        buf_vld_d = buf_vld_q;
        ld_clear  = 1'b0;
        rb_clear  = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_d   = ST_LOAD;
                    bit_cnt_d = '0;
                    buf_vld_d = 1'b0;
                    idx_d     = 3'd0;
                    ld_clear  = 1'b1;
                end
            end
            ST_LOAD: begin
                if (ld_shift) begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    idx_d     = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        buf_vld_d = 1'b0;
                    end
                    // Final chain bit: drop the rest of the byte and start readback.
                    if (last_bit) begin
                        state_d   = ST_VERIFY;
                        bit_cnt_d = '0;
                        buf_vld_d = 1'b0;
                        idx_d     = 3'd0;
                        rb_clear  = 1'b1;
                    end
                end else if (s_valid) begin
                    buf_d     = s_data;
                    idx_d     = 3'd0;
                    buf_vld_d = 1'b1;
                end
            end
            ST_VERIFY: begin
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (last_bit) begin
                    bit_cnt_d = '0;
                    state_d   = (crc16_step(crc_rb, prog_out) == crc_ld) ? ST_DONE : ST_ERROR;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort && (state_q == ST_LOAD || state_q == ST_VERIFY)) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            buf_vld_d = 1'b0;
            idx_d     = 3'd0;
        end
    end

    // Status outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            buf_q        <= 8'h00;
            idx_q        <= 3'd0;
            buf_vld_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            crc_err_q    <= 1'b0;
            fabric_rst_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            buf_q        <= buf_d;
            idx_q        <= idx_d;
            buf_vld_q    <= buf_vld_d;
            busy_q       <= (state_d == ST_LOAD) || (state_d == ST_VERIFY);
            done_q       <= (state_d == ST_DONE);
            crc_err_q    <= (state_d == ST_ERROR);
            fabric_rst_q <= (state_d != ST_DONE);
        end
    end

    crc16_serial #(.INIT(CRC_INIT)) u_crc_ld (
        .clk    (clk),
        .rst    (rst),
        .clear  (ld_clear),
        .en     (ld_shift),
        .bit_in (prog_in),
        .crc    (crc_ld)
    );

    crc16_serial #(.INIT(CRC_INIT)) u_crc_rb (
        .clk    (clk),
        .rst    (rst),
        .clear  (rb_clear),
        .en     (rb_shift),
        .bit_in (prog_out),
        .crc    (crc_rb)
    );

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Directed bench for cfg_chain_loader: 176-bit build plus a 13-bit build, each with a
// behavioural chain shift register on prog_en/prog_in.
module tb_cfg_chain_loader;

    localparam int N = 176;
    localparam int M = 13;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, abort, s_valid, prog_out;
    logic [7:0] s_data;
    logic       s_ready, prog_en, prog_in, fabric_rst, busy, done, crc_err;

    logic       start13, abort13, s_valid13, prog_out13;
    logic [7:0] s_data13;
    logic       s_ready13, prog_en13, prog_in13, fabric_rst13, busy13, done13, crc_err13;

    int vectors = 0;
    int miscompares = 0;

    cfg_chain_loader #(.CHAIN_LEN(N), .CNT_W(8), .CRC_INIT(16'hFFFF)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .prog_en(prog_en), .prog_in(prog_in), .prog_out(prog_out),
        .fabric_rst(fabric_rst), .busy(busy), .done(done), .crc_err(crc_err)
    );

    cfg_chain_loader #(.CHAIN_LEN(M), .CNT_W(4), .CRC_INIT(16'hFFFF)) dut13 (
        .clk(clk), .rst(rst), .start(start13), .abort(abort13),
        .s_data(s_data13), .s_valid(s_valid13), .s_ready(s_ready13),
        .prog_en(prog_en13), .prog_in(prog_in13), .prog_out(prog_out13),
        .fabric_rst(fabric_rst13), .busy(busy13), .done(done13), .crc_err(crc_err13)
    );

    // Chain models: stream bit i ends up at index i, the tail is index 0.
    logic [N-1:0] chain = '0;
    logic [M-1:0] chain13 = '0;
    logic         en_s, in_s, en13_s, in13_s;
    logic         flip_now = 1'b0;
    int           flip_idx = 50;

    assign prog_out   = chain[0];
    assign prog_out13 = chain13[0];

    always @(negedge clk) begin
        en_s   <= prog_en;
        in_s   <= prog_in;
        en13_s <= prog_en13;
        in13_s <= prog_in13;
    end

    function automatic logic [N-1:0] next_chain(input logic [N-1:0] c, input logic flip,
                                                input logic en, input logic bin);
        logic [N-1:0] r;
        r = c;
        if (flip) r[flip_idx] = ~r[flip_idx];
        if (en) r = {bin, r[N-1:1]};
        return r;
    endfunction

    always @(posedge clk) begin
        chain <= next_chain(chain, flip_now, en_s, in_s);
        if (en13_s) chain13 <= {in13_s, chain13[M-1:1]};
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] exp_chain(input logic [7:0] pat);
        logic [N-1:0] e;
        for (int i = 0; i < N; i++) e[i] = pat[i % 8];
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulses start, streams 22 bytes of pat and runs until stop_en chain shifts were seen.
    task automatic run_config(input logic [7:0] pat, input int stall_after, input int flip_at,
                              input int stop_en, output int en_cnt, output int bytes,
                              output int stall_en);
        int stall_cnt;
        int cyc;
        logic in_stall;
        stall_cnt = 0;
        cyc = 0;
        en_cnt = 0;
        bytes = 0;
        stall_en = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (en_cnt != stop_en && cyc < 3000) begin
            in_stall = (bytes == stall_after) && s_ready && (stall_cnt < 7);
            if (in_stall) begin
                s_valid = 1'b0;
                stall_cnt++;
            end else begin
                s_valid = (bytes < 22);
            end
            s_data = pat;
            flip_now = (flip_at >= 0) && (en_cnt == flip_at);
            #1;
            if (s_valid && s_ready) bytes++;
            if (prog_en) en_cnt++;
            if (in_stall) stall_en += int'(prog_en);
            @(posedge clk);
            #1;
            cyc++;
        end
        s_valid = 1'b0;
        flip_now = 1'b0;
        check("shift_count", en_cnt, stop_en);
    endtask

    initial begin
        int en_cnt, bytes, stall_en, en_after, en13, bytes13, cyc;

        rst = 1'b1; start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = 8'h00;
        start13 = 1'b0; abort13 = 1'b0; s_valid13 = 1'b0; s_data13 = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: idle after reset
        repeat (5) tick();
        #1;
        check("rst_fabric_rst", fabric_rst, 1'b1);
        check("rst_prog_en", prog_en, 1'b0);
        check("rst_s_ready", s_ready, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_crc_err", crc_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst13_fabric_rst", fabric_rst13, 1'b1);

        // 2: clean back-to-back load of 0xA5
        tick();
        run_config(8'hA5, -1, -1, 2 * N, en_cnt, bytes, stall_en);
        check("t2_done", done, 1'b1);
        check("t2_fabric_rst", fabric_rst, 1'b0);
        check("t2_crc_err", crc_err, 1'b0);
        check("t2_busy", busy, 1'b0);
        check("t2_bytes", bytes, 22);
        check("t2_chain", chain, exp_chain(8'hA5));
        #1;
        check("t2_prog_en_after", prog_en, 1'b0);

        // 3: 7-cycle source stall once byte 3 has drained
        tick();
        run_config(8'hA5, 3, -1, 2 * N, en_cnt, bytes, stall_en);
        check("t3_stall_prog_en", stall_en, 0);
        check("t3_done", done, 1'b1);
        check("t3_chain", chain, exp_chain(8'hA5));

        // 4: corrupt chain index 50 during readback, then reload cleanly
        tick();
        run_config(8'h3C, -1, N + 10, 2 * N, en_cnt, bytes, stall_en);
        check("t4_crc_err", crc_err, 1'b1);
        check("t4_done", done, 1'b0);
        check("t4_fabric_rst", fabric_rst, 1'b1);
        check("t4_busy", busy, 1'b0);
        tick();
        run_config(8'h3C, -1, -1, 2 * N, en_cnt, bytes, stall_en);
        check("t4_reload_crc_err", crc_err, 1'b0);
        check("t4_reload_done", done, 1'b1);
        check("t4_reload_chain", chain, exp_chain(8'h3C));

        // 5a: abort after 40 load bits
        tick();
        run_config(8'h5A, -1, -1, 40, en_cnt, bytes, stall_en);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t5_abort_busy", busy, 1'b0);
        check("t5_abort_s_ready", s_ready, 1'b0);
        check("t5_abort_fabric_rst", fabric_rst, 1'b1);
        check("t5_abort_done", done, 1'b0);
        en_after = 0;
        s_valid = 1'b1;
        repeat (20) begin
            #1;
            if (prog_en) en_after++;
            tick();
        end
        s_valid = 1'b0;
        check("t5_abort_no_shift", en_after, 0);

        // 5b: reset after 100 readback bits
        run_config(8'h5A, -1, -1, N + 100, en_cnt, bytes, stall_en);
        rst = 1'b1;
        tick();
        check("t5_rst_busy", busy, 1'b0);
        check("t5_rst_prog_en", prog_en, 1'b0);
        check("t5_rst_prog_in", prog_in, 1'b0);
        check("t5_rst_s_ready", s_ready, 1'b0);
        check("t5_rst_fabric_rst", fabric_rst, 1'b1);
        check("t5_rst_done", done, 1'b0);
        check("t5_rst_crc_err", crc_err, 1'b0);
        rst = 1'b0;
        tick();

        // 6: 13-bit chain, bytes 0xFF, 0x0F, then a surplus byte that must not be taken
        start13 = 1'b1;
        tick();
        start13 = 1'b0;
        en13 = 0;
        bytes13 = 0;
        cyc = 0;
        while (busy13 && cyc < 300) begin
            s_valid13 = 1'b1;
            s_data13 = (bytes13 == 0) ? 8'hFF : ((bytes13 == 1) ? 8'h0F : 8'h00);
            #1;
            if (s_valid13 && s_ready13) bytes13++;
            if (prog_en13) en13++;
            tick();
            cyc++;
        end
        s_valid13 = 1'b0;
        check("t6_shift_count", en13, 2 * M);
        check("t6_bytes", bytes13, 2);
        check("t6_chain", chain13, 13'h0FFF);
        check("t6_done", done13, 1'b1);
        check("t6_fabric_rst", fabric_rst13, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
